ldst_unit: RTL

- Load/store unit between the CPU execute stage and the data-memory port.
- Accepts one decoded load/store request at a time:
  - generates the word-aligned bus address, byte enables and lane-replicated store data;
  - honours i_ldst_waitrequest;
  - waits a fixed read latency;
  - returns sign- or zero-extended load data to write-back.
- Single outstanding transaction; the CPU stalls on o_req_ready.

---
 rtl/ldst_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ldst_unit.sv
// Load/store unit: one outstanding request, aligned bus command, fixed read latency, extended load data.
// Optional LDST_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module ldst_unit #(
    parameter int IW         = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_wr,
    input  logic [2:0]    i_req_funct3,
    input  logic [IW-1:0] i_req_addr,
    input  logic [IW-1:0] i_req_wrdata,
    output logic          o_resp_valid,
    output logic [IW-1:0] o_resp_rddata,
    output logic          o_resp_err,
    output logic [IW-1:0] o_ldst_addr,
    output logic          o_ldst_rd,
    output logic          o_ldst_wr,
    output logic [IW-1:0] o_ldst_wrdata,
    output logic [3:0]    o_ldst_byte_en,
    input  logic [IW-1:0] i_ldst_rddata,
    input  logic          i_ldst_waitrequest
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_M1 = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;

    state_t        r_state, w_next;
    logic          r_wr;
    logic [2:0]    r_funct3;
    logic [IW-1:0] r_addr;
    logic [IW-1:0] r_wrdata;
    logic [2:0]    r_cnt;
    logic          r_err;
    logic [IW-1:0] r_rddata;

    logic          w_f3_ok;
    logic          w_misalign;
    logic          w_sample;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [IW-1:0] w_load_ext;

    assign w_f3_ok = i_req_wr ? (i_req_funct3 <= 3'd2)
                              : (i_req_funct3 != 3'd3 && i_req_funct3 != 3'd6 && i_req_funct3 != 3'd7);

`ifdef LDST_MISALIGN_CHECK_EN
    assign w_misalign = (i_req_funct3[1:0] == 2'd1 && i_req_addr[0]) ||
                        (i_req_funct3[1:0] == 2'd2 && i_req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_byte = 8'(i_ldst_rddata >> {r_addr[1:0], 3'b000});
    assign w_half = 16'(i_ldst_rddata >> {r_addr[1], 4'b0000});

    always_comb begin
        case (r_funct3)
            3'd0:    w_load_ext = {{(IW-8){w_byte[7]}}, w_byte};
            3'd1:    w_load_ext = {{(IW-16){w_half[15]}}, w_half};
            3'd4:    w_load_ext = {{(IW-8){1'b0}}, w_byte};
            3'd5:    w_load_ext = {{(IW-16){1'b0}}, w_half};
            default: w_load_ext = i_ldst_rddata;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_sample = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid)
                    w_next = (!w_f3_ok || w_misalign) ? S_RESP : S_ISSUE;
            end
            S_ISSUE: begin
                if (!i_ldst_waitrequest) begin
                    if (r_wr) begin
                        w_next = S_RESP;
                    end else if (RD_LATENCY == 0) begin
                        w_sample = 1'b1;
                        w_next   = S_RESP;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_sample = 1'b1;
                    w_next   = S_RESP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wr     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wrdata <= '0;
            r_cnt    <= 3'd0;
            r_err    <= 1'b0;
            r_rddata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_req_valid) begin
                r_wr     <= i_req_wr;
                r_funct3 <= i_req_funct3;
                r_addr   <= i_req_addr;
                r_wrdata <= i_req_wrdata;
                r_err    <= !w_f3_ok || w_misalign;
            end
            if (r_state == S_ISSUE)
                r_cnt <= LAT_M1;
            else if (r_state == S_WAIT && r_cnt != 3'd0)
                r_cnt <= r_cnt - 3'd1;
            // Response data only changes when a new response is produced
            if (w_next == S_RESP && r_state != S_RESP)
                r_rddata <= w_sample ? w_load_ext : '0;
        end
    end

    always_comb begin
        o_ldst_addr    = '0;
        o_ldst_rd      = 1'b0;
        o_ldst_wr      = 1'b0;
        o_ldst_wrdata  = '0;
        o_ldst_byte_en = 4'b0000;
        if (r_state == S_ISSUE) begin
            o_ldst_addr = {r_addr[IW-1:2], 2'b00};
            o_ldst_rd   = ~r_wr;
            o_ldst_wr   = r_wr;
            case (r_funct3[1:0])
                2'd0: begin
                    o_ldst_byte_en = 4'b0001 << r_addr[1:0];
                    o_ldst_wrdata  = {(IW/8){r_wrdata[7:0]}};
                end
                2'd1: begin
                    o_ldst_byte_en = 4'b0011 << {r_addr[1], 1'b0};
                    o_ldst_wrdata  = {(IW/16){r_wrdata[15:0]}};
                end
                default: begin
                    o_ldst_byte_en = 4'b1111;
                    o_ldst_wrdata  = r_wrdata;
                end
            endcase
        end
    end

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_resp_valid  = (r_state == S_RESP);
    assign o_resp_err    = (r_state == S_RESP) && r_err;
    assign o_resp_rddata = r_rddata;

endmodule
